irq_cause_arbiter: RTL and testbench

- Collects up to N_SRC interrupt request lines and latches them into a pending register.
- Selects one enabled pending source and presents it to the core as a single interrupt with a 6-bit cause code: {1'b1, 5-bit source index}.
- Holds the presented cause stable until the core acknowledges it, then retires that source.
- Sits between the per-unit irq outputs and the core trap logic; it sequences and shares the single cause channel.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_prio_sel.sv | 57 +++++
 rtl/irq_cause_arbiter.sv | 151 +++++++++++++++
 tb/tb_irq_cause_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Definitions shared by the interrupt cause arbiter and its selector.
//   irq_state_e     : arbiter state (IDLE / PRESENT)
//   IRQ_CAUSE_FLAG  : constant flag bit that sits above the source index
//   irq_make_cause  : builds {IRQ_CAUSE_FLAG, index} for a given index width
// ---------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

    localparam logic IRQ_CAUSE_FLAG = 1'b1;

    // Places the flag at bit position cause_w and the zero-extended index below
    // it. The caller truncates the result to cause_w+1 bits.
    function automatic logic [32:0] irq_make_cause(input logic [31:0] idx,
                                                   input int unsigned cause_w);
        logic [32:0] cause;
        cause = {1'b0, idx};
        cause = cause | ({32'd0, IRQ_CAUSE_FLAG} << cause_w);
        return cause;
    endfunction

endpackage : irq_pkg

// File: rtl/irq_prio_sel.sv
// ---------------------------------------------------------------------------
// irq_prio_sel
// Combinational circular priority selector. Returns the first set bit of
// mask_i found when scanning upward from start_i and wrapping past N-1 to 0.
// With start_i tied to zero this is plain lowest-index-wins priority.
// Ports:
//   mask_i   [N-1:0]   candidate bits
//   start_i  [IW-1:0]  first index to consider (must be < N)
//   idx_o    [IW-1:0]  selected index (0 when nothing found)
//   found_o            at least one candidate bit was set
// ---------------------------------------------------------------------------
module irq_prio_sel #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 5
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic          found_hi_s;
    logic          found_lo_s;
    logic [IW-1:0] idx_hi_s;
    logic [IW-1:0] idx_lo_s;

    // Two descending scans: the last hit written is the lowest index overall
    // (lo) and the lowest index at or above start_i (hi). hi wins if present,
    // otherwise the search has wrapped and lo is the answer.
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        idx_hi_s   = {IW{1'b0}};
        idx_lo_s   = {IW{1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            if (mask_i[j]) begin
                found_lo_s = 1'b1;
                idx_lo_s   = IW'(j);
                if (IW'(j) >= start_i) begin
                    found_hi_s = 1'b1;
                    idx_hi_s   = IW'(j);
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        found_o = found_lo_s;
        if (found_hi_s) begin
            idx_o = idx_hi_s;
        end else begin
            idx_o = idx_lo_s;
        end
    end

endmodule : irq_prio_sel

// File: rtl/irq_cause_arbiter.sv
// ---------------------------------------------------------------------------
// irq_cause_arbiter
// Latches N_SRC level interrupt requests into a pending register, picks one
// enabled pending source and presents it to the core as a single interrupt
// with cause {1'b1, index}. The cause is held until io_irq_ack, then the
// source is retired (a request still active in the ack cycle re-pends it).
// Optional macro IRQ_RR_EN: round-robin selection starting after the last
// acknowledged index; without it, lowest index wins.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   io_src         level request per source
//   io_enable      per-source selection enable (latching is unaffected)
//   io_irq         registered interrupt valid
//   io_irq_cause   registered {1'b1, index}, zero when io_irq=0
//   io_irq_ack     core accepts the presented cause
//   io_pending     pending register mirror
// ---------------------------------------------------------------------------
module irq_cause_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC   = 8,
    parameter int unsigned CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   io_src,
    input  logic [N_SRC-1:0]   io_enable,
    output logic               io_irq,
    output logic [CAUSE_W:0]   io_irq_cause,
    input  logic               io_irq_ack,
    output logic [N_SRC-1:0]   io_pending
);

    irq_state_e         state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [CAUSE_W-1:0] cur_idx_q, cur_idx_d;
    logic               irq_q, irq_d;
    logic [CAUSE_W:0]   cause_q, cause_d;

    logic               ack_accept_s;
    logic [N_SRC-1:0]   clear_vec_s;
    logic [CAUSE_W-1:0] start_s;
    logic [CAUSE_W-1:0] sel_idx_s;
    logic               sel_found_s;

    assign ack_accept_s = (state_q == PRESENT) && io_irq_ack;

    // Pending update: clear the acked source, then OR in requests so a source
    // still requesting in its ack cycle stays pending.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            clear_vec_s[i] = ack_accept_s && (cur_idx_q == CAUSE_W'(i));
        end
        pending_d = (pending_q & ~clear_vec_s) | io_src;
    end

`ifdef IRQ_RR_EN
    logic [CAUSE_W-1:0] last_idx_q, last_idx_d;

    // Round-robin bookkeeping: remember the last acked index, start after it.
    always_comb begin
        if (ack_accept_s) begin
            last_idx_d = cur_idx_q;
        end else begin
            last_idx_d = last_idx_q;
        end
        if (last_idx_q == CAUSE_W'(N_SRC - 1)) begin
            start_s = {CAUSE_W{1'b0}};
        end else begin
            start_s = last_idx_q + CAUSE_W'(1);
        end
    end

    // Last-acked index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx_q <= {CAUSE_W{1'b0}};
        end else begin
            last_idx_q <= last_idx_d;
        end
    end
`else
    assign start_s = {CAUSE_W{1'b0}};
`endif

    irq_prio_sel #(
        .N  (N_SRC),
        .IW (CAUSE_W)
    ) u_sel (
        .mask_i  (pending_q & io_enable),
        .start_i (start_s),
        .idx_o   (sel_idx_s),
        .found_o (sel_found_s)
    );

    // Next state and registered-output values. cur_idx only moves in IDLE so
    // the presented cause cannot be preempted or withdrawn by enable changes.
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    state_d   = PRESENT;
                    cur_idx_d = sel_idx_s;
                end else begin
                    state_d   = IDLE;
                end
            end
            PRESENT: begin
                if (io_irq_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d   = IDLE;
                cur_idx_d = {CAUSE_W{1'b0}};
            end
        endcase
        irq_d = (state_d == PRESENT);
        if (irq_d) begin
            cause_d = (CAUSE_W + 1)'(irq_make_cause(32'(cur_idx_d), CAUSE_W));
        end else begin
            cause_d = {(CAUSE_W + 1){1'b0}};
        end
    end

    // State, pending and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= {N_SRC{1'b0}};
            cur_idx_q <= {CAUSE_W{1'b0}};
            irq_q     <= 1'b0;
            cause_q   <= {(CAUSE_W + 1){1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_idx_q <= cur_idx_d;
            irq_q     <= irq_d;
            cause_q   <= cause_d;
        end
    end

    assign io_irq       = irq_q;
    assign io_irq_cause = cause_q;
    assign io_pending   = pending_q;

endmodule : irq_cause_arbiter

// File: tb/tb_irq_cause_arbiter.sv
module tb_irq_cause_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] io_src;
    logic [7:0] io_enable;
    logic       io_irq;
    logic [5:0] io_irq_cause;
    logic       io_irq_ack;
    logic [7:0] io_pending;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_pend;
    bit         m_pres;
    int         m_idx;
    int         m_last;

    irq_cause_arbiter #(.N_SRC(8), .CAUSE_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_src       (io_src),
        .io_enable    (io_enable),
        .io_irq       (io_irq),
        .io_irq_cause (io_irq_cause),
        .io_irq_ack   (io_irq_ack),
        .io_pending   (io_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the behavioural model, from the rules directly.
    task automatic model_edge();
        logic [7:0] cand;
        int start;
        bit hit;
        if (reset) begin
            m_pend = 8'h00; m_pres = 0; m_idx = 0; m_last = 0;
        end else begin
            cand = m_pend & io_enable;
            if (m_pres) begin
                if (io_irq_ack) begin
                    m_pend[m_idx] = 1'b0;
                    m_last = m_idx;
                    m_pres = 0;
                end
            end else begin
`ifdef IRQ_RR_EN
                start = (m_last + 1) % N;
`else
                start = 0;
`endif
                hit = 0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && cand[(start + k) % N]) begin
                        hit = 1;
                        m_idx = (start + k) % N;
                    end
                end
                m_pres = hit;
            end
            m_pend = m_pend | io_src;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_irq", 32'(io_irq), 32'(m_pres));
        check("model_cause", 32'(io_irq_cause), m_pres ? 32'(32 + m_idx) : 32'd0);
        check("model_pending", 32'(io_pending), 32'(m_pend));
    endtask

    task automatic expect_out(input string name, input logic irq, input logic [5:0] cause,
                              input logic [7:0] pend);
        check({name, "_irq"}, 32'(io_irq), 32'(irq));
        check({name, "_cause"}, 32'(io_irq_cause), 32'(cause));
        check({name, "_pending"}, 32'(io_pending), 32'(pend));
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] src;
        logic [7:0] en;
        logic       ack;
        logic       e_irq;
        logic [5:0] e_cause;
        logic [7:0] e_pend;
    } vec_t;

    vec_t vecs[19];
    logic [5:0] rr_exp[4];

    initial begin
        reset = 1'b1; io_src = 8'h00; io_enable = 8'hFF; io_irq_ack = 1'b0;
        m_pend = 8'h00; m_pres = 0; m_idx = 0; m_last = 0;

        // rst, src, en, ack -> irq, cause, pending (after the edge)
        vecs[0]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 6'h00, 8'hFF};
`ifdef IRQ_RR_EN
        vecs[3]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h21, 8'hFF};
        vecs[4]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'hFD};
        vecs[5]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h22, 8'hFD};
        vecs[6]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'hF9};
`else
        vecs[3]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h20, 8'hFF};
        vecs[4]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'hFE};
        vecs[5]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h21, 8'hFE};
        vecs[6]  = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'hFC};
`endif
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'h24, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h24};
        vecs[9]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h22, 8'h24};
        vecs[10] = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'h20};
        vecs[11] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 6'h25, 8'h20};
        vecs[12] = '{1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 6'h00, 8'h00};
        vecs[13] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00};
        vecs[14] = '{1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 6'h00, 8'h08};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h08};
        vecs[16] = '{1'b0, 8'h00, 8'h08, 1'b0, 1'b1, 6'h23, 8'h08};
        vecs[17] = '{1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 6'h00, 8'h00};
        vecs[18] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 6'h00, 8'h00};

        for (int v = 0; v < 19; v++) begin
            reset = vecs[v].rst; io_src = vecs[v].src;
            io_enable = vecs[v].en; io_irq_ack = vecs[v].ack;
            tick();
            expect_out($sformatf("vec%0d", v), vecs[v].e_irq, vecs[v].e_cause, vecs[v].e_pend);
        end

        // Stability and set-wins
        reset = 1'b1; io_src = 8'h00; io_enable = 8'hFF; io_irq_ack = 1'b0; tick();
        reset = 1'b0; io_src = 8'h02; tick();
        expect_out("sw_latch", 1'b0, 6'h00, 8'h02);
        tick();
        expect_out("sw_present", 1'b1, 6'h21, 8'h02);
        io_src = 8'h03; tick();
        expect_out("sw_hold0", 1'b1, 6'h21, 8'h03);
        io_src = 8'h02; tick();
        expect_out("sw_hold1", 1'b1, 6'h21, 8'h03);
        io_irq_ack = 1'b1; tick();
        expect_out("sw_ack", 1'b0, 6'h00, 8'h03);
        io_irq_ack = 1'b0; io_src = 8'h00; tick();
        expect_out("sw_next0", 1'b1, 6'h20, 8'h03);
        io_irq_ack = 1'b1; tick();
        expect_out("sw_ack0", 1'b0, 6'h00, 8'h02);
        io_irq_ack = 1'b0; tick();
        expect_out("sw_again1", 1'b1, 6'h21, 8'h02);

        // Reset while presenting
        reset = 1'b1; tick();
        expect_out("rstp_0", 1'b0, 6'h00, 8'h00);
        reset = 1'b0; tick();
        expect_out("rstp_1", 1'b0, 6'h00, 8'h00);
        tick();
        expect_out("rstp_2", 1'b0, 6'h00, 8'h00);

        // Held requests, ack every presentation
`ifdef IRQ_RR_EN
        rr_exp = '{6'h21, 6'h22, 6'h20, 6'h21};
`else
        rr_exp = '{6'h20, 6'h20, 6'h20, 6'h20};
`endif
        reset = 1'b1; tick();
        reset = 1'b0; io_src = 8'h07; tick();
        for (int k = 0; k < 4; k++) begin
            io_irq_ack = 1'b0; tick();
            check($sformatf("seq_cause%0d", k), 32'(io_irq_cause), 32'(rr_exp[k]));
            io_irq_ack = 1'b1; tick();
            check($sformatf("seq_drop%0d", k), 32'(io_irq), 32'd0);
        end

        // Randomized traffic against the model
        io_irq_ack = 1'b0; io_src = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 99) < 2);
            io_src     = 8'($urandom) & 8'($urandom) & 8'($urandom);
            io_enable  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            io_irq_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_irq_cause_arbiter
